// File: rtl/debug_cmd_sysclk_bridge.sv
// System-clock side of the CPU debug slave: synchronises update strobes
// from TCK, buffers {ir, sr} commands in a FIFO and replays them in clk.
//
// Ports:
//   clk, reset_n     system clock, async active-low reset
//   sr, ir_in        TCK-domain DR/IR contents, stable while vs_udr high
//   vs_udr, vs_uir   async update-DR / update-IR levels
//   cmd_ready        consumer accepts the head command
//   clr_overflow     clears the overflow sticky
//   jdo              data of the last accepted command
//   cmd_valid        FIFO non-empty
//   cmd_ir           instruction of the head entry
//   take_action      one-hot strobe (index = ir) when sr[ACTION_BIT]=1
//   take_no_action   one-hot strobe (index = ir) when sr[ACTION_BIT]=0
//   ir_update        one-cycle pulse on synchronised vs_uir rise
//   fifo_level       occupied entries
//   overflow         sticky: a capture was dropped on a full FIFO
module debug_cmd_sysclk_bridge #(
  parameter int DR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int ACTION_BIT  = 35,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [DR_WIDTH-1:0]             sr,
  input  logic [IR_WIDTH-1:0]             ir_in,
  input  logic                            vs_udr,
  input  logic                            vs_uir,
  input  logic                            cmd_ready,
  input  logic                            clr_overflow,
  output logic [DR_WIDTH-1:0]             jdo,
  output logic                            cmd_valid,
  output logic [IR_WIDTH-1:0]             cmd_ir,
  output logic [(2**IR_WIDTH)-1:0]        take_action,
  output logic [(2**IR_WIDTH)-1:0]        take_no_action,
  output logic                            ir_update,
  output logic [$clog2(FIFO_DEPTH):0]     fifo_level,
  output logic                            overflow
);

  localparam int NCMD = 2**IR_WIDTH;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int LW   = AW + 1;
  localparam int EW   = IR_WIDTH + DR_WIDTH;

  // ---------------------------------------------------------------
  // Strobe synchronisers
  // ---------------------------------------------------------------
  logic [SYNC_STAGES-1:0] udr_sync;
  logic [SYNC_STAGES-1:0] uir_sync;
  logic [SYNC_STAGES-1:0] primed;
  logic                   udr_lvl;
  logic                   uir_lvl;
  logic                   udr_prev;
  logic                   uir_prev;
  logic                   udr_arm;
  logic                   uir_arm;
  logic                   udr_rise;
  logic                   uir_rise;

  assign udr_lvl = udr_sync[SYNC_STAGES-1];
  assign uir_lvl = uir_sync[SYNC_STAGES-1];

  // primed marks when the sync chain holds real samples rather than
  // reset zeros. A channel arms only once it has seen its level low,
  // so a level already high at reset release is not taken as an edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udr_sync <= '0;
      uir_sync <= '0;
      primed   <= '0;
      udr_prev <= 1'b0;
      uir_prev <= 1'b0;
      udr_arm  <= 1'b0;
      uir_arm  <= 1'b0;
    end else begin
      udr_sync <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      primed   <= {primed[SYNC_STAGES-2:0], 1'b1};
      udr_prev <= udr_lvl;
      uir_prev <= uir_lvl;
      udr_arm  <= udr_arm | (primed[SYNC_STAGES-1] & ~udr_lvl);
      uir_arm  <= uir_arm | (primed[SYNC_STAGES-1] & ~uir_lvl);
    end
  end

  assign udr_rise = udr_lvl & ~udr_prev & udr_arm;
  assign uir_rise = uir_lvl & ~uir_prev & uir_arm;

  // ---------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------
  logic [EW-1:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr;
  logic [AW-1:0]       rd_ptr;
  logic [LW-1:0]       count;
  logic [EW-1:0]       head;
  logic [DR_WIDTH-1:0] head_sr;
  logic [IR_WIDTH-1:0] head_ir;
  logic                full;
  logic                pop;
  logic                push;
  logic                drop;
  logic [NCMD-1:0]     sel;

  assign head      = mem[rd_ptr];
  assign head_sr   = head[DR_WIDTH-1:0];
  assign head_ir   = head[EW-1:DR_WIDTH];
  assign full      = (count == LW'(FIFO_DEPTH));
  assign cmd_valid = (count != '0);
  assign cmd_ir    = cmd_valid ? head_ir : '0;
  assign fifo_level = count;

  // A pop frees the head slot this edge, so a full FIFO can still
  // accept a capture that lands together with a pop.
  assign pop  = cmd_valid & cmd_ready;
  assign push = udr_rise & (~full | pop);
  assign drop = udr_rise & full & ~pop;
  assign sel  = NCMD'(1) << head_ir;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      mem[wr_ptr] <= {ir_in, sr};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // ---------------------------------------------------------------
  // Replay outputs
  // ---------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= uir_rise;
      if (pop) begin
        jdo <= head_sr;
        if (head_sr[ACTION_BIT]) begin
          take_action <= sel;
        end else begin
          take_no_action <= sel;
        end
      end
      if (drop) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_debug_cmd_sysclk_bridge.sv
// Directed bench for debug_cmd_sysclk_bridge with a command scoreboard.
// Expected commands are queued at capture and retired on each strobe.
module tb_debug_cmd_sysclk_bridge;

  typedef struct packed {
    logic [1:0]  ir;
    logic [37:0] sr;
  } cmd_t;

  logic        clk;
  logic        reset_n;
  logic [37:0] sr;
  logic [1:0]  ir_in;
  logic        vs_udr;
  logic        vs_uir;
  logic        cmd_ready;
  logic        clr_overflow;
  logic [37:0] jdo;
  logic        cmd_valid;
  logic [1:0]  cmd_ir;
  logic [3:0]  take_action;
  logic [3:0]  take_no_action;
  logic        ir_update;
  logic [2:0]  fifo_level;
  logic        overflow;

  int   n_assert;
  int   n_fail;
  cmd_t sb[$];

  debug_cmd_sysclk_bridge dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .sr             (sr),
    .ir_in          (ir_in),
    .vs_udr         (vs_udr),
    .vs_uir         (vs_uir),
    .cmd_ready      (cmd_ready),
    .clr_overflow   (clr_overflow),
    .jdo            (jdo),
    .cmd_valid      (cmd_valid),
    .cmd_ir         (cmd_ir),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .ir_update      (ir_update),
    .fifo_level     (fifo_level),
    .overflow       (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [37:0] d,
                      input logic [1:0] i,
                      input bit store);
    cmd_t c;
    sr     = d;
    ir_in  = i;
    vs_udr = 1'b1;
    if (store) begin
      c.ir = i;
      c.sr = d;
      sb.push_back(c);
    end
    tick(6);
    vs_udr = 1'b0;
    tick(4);
  endtask

  task automatic check_reset_outs();
    check("rst_jdo", jdo, 0);
    check("rst_valid", cmd_valid, 0);
    check("rst_cmd_ir", cmd_ir, 0);
    check("rst_ta", take_action, 0);
    check("rst_tna", take_no_action, 0);
    check("rst_ir_update", ir_update, 0);
    check("rst_level", fifo_level, 0);
    check("rst_overflow", overflow, 0);
  endtask

  // Scoreboard: every strobe retires the oldest expected command.
  always @(negedge clk) begin
    cmd_t       e;
    logic [3:0] oh;
    if (reset_n &&
        (take_action != 4'b0 || take_no_action != 4'b0)) begin
      if (sb.size() == 0) begin
        check("unexpected_strobe",
              {take_action, take_no_action}, 0);
      end else begin
        e  = sb.pop_front();
        oh = 4'b0001 << e.ir;
        check("sb_jdo", jdo, e.sr);
        check("sb_ta", take_action, e.sr[35] ? oh : 4'b0);
        check("sb_tna", take_no_action, e.sr[35] ? 4'b0 : oh);
      end
    end
  end

  initial begin
    cmd_t c;
    n_assert     = 0;
    n_fail       = 0;
    reset_n      = 1'b0;
    sr           = '0;
    ir_in        = '0;
    vs_udr       = 1'b0;
    vs_uir       = 1'b0;
    cmd_ready    = 1'b0;
    clr_overflow = 1'b0;

    tick(2);
    check_reset_outs();
    reset_n = 1'b1;
    tick(5);

    // single command, latency and one-cycle strobe
    cmd_ready = 1'b1;
    sr        = 38'h2_0000_00AB;
    ir_in     = 2'd2;
    vs_udr    = 1'b1;
    c.ir = 2'd2;
    c.sr = 38'h2_0000_00AB;
    sb.push_back(c);
    tick(2);
    check("t1_valid_early", cmd_valid, 0);
    tick(1);
    check("t1_valid", cmd_valid, 1);
    check("t1_cmd_ir", cmd_ir, 2);
    check("t1_level", fifo_level, 1);
    tick(1);
    check("t1_jdo", jdo, 38'h2_0000_00AB);
    check("t1_tna", take_no_action, 4'b0100);
    check("t1_ta", take_action, 0);
    check("t1_valid_after", cmd_valid, 0);
    tick(1);
    check("t1_tna_off", take_no_action, 0);
    tick(1);
    vs_udr = 1'b0;
    tick(5);

    // action bit set
    send(38'h08_1234_5678, 2'd1, 1'b1);
    check("t2_jdo", jdo, 38'h08_1234_5678);
    check("t2_drained", sb.size(), 0);

    // back-pressure and overflow
    cmd_ready = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      send(38'(k), 2'd0, k <= 4);
    end
    check("t3_level", fifo_level, 4);
    check("t3_overflow", overflow, 1);
    check("t3_valid", cmd_valid, 1);
    cmd_ready = 1'b1;
    tick(6);
    check("t3_level_empty", fifo_level, 0);
    check("t3_drained", sb.size(), 0);
    check("t3_jdo_last", jdo, 4);
    check("t3_overflow_held", overflow, 1);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("t3_overflow_clr", overflow, 0);

    // full with simultaneous pop
    cmd_ready = 1'b0;
    for (int k = 10; k <= 13; k++) begin
      send(38'(k) | ((k % 2 == 1) ? (38'd1 << 35) : 38'd0),
           2'd3, 1'b1);
    end
    check("t4_full", fifo_level, 4);
    sr     = 38'd14 | (38'd1 << 35);
    ir_in  = 2'd3;
    vs_udr = 1'b1;
    c.ir = 2'd3;
    c.sr = 38'd14 | (38'd1 << 35);
    sb.push_back(c);
    tick(2);
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("t4_level_same", fifo_level, 4);
    check("t4_no_overflow", overflow, 0);
    check("t4_jdo_first", jdo, 10);
    tick(3);
    vs_udr = 1'b0;
    tick(4);
    cmd_ready = 1'b1;
    tick(6);
    cmd_ready = 1'b0;
    check("t4_level_empty", fifo_level, 0);
    check("t4_drained", sb.size(), 0);
    check("t4_jdo_last", jdo, 38'd14 | (38'd1 << 35));

    // ir_update pulse
    vs_uir = 1'b1;
    tick(2);
    check("t5_iru_early", ir_update, 0);
    tick(1);
    check("t5_iru", ir_update, 1);
    check("t5_level", fifo_level, 0);
    tick(1);
    check("t5_iru_off", ir_update, 0);
    tick(3);
    vs_uir = 1'b0;
    tick(4);
    check("t5_valid", cmd_valid, 0);

    // clr_overflow together with a drop: set wins
    for (int k = 20; k <= 23; k++) begin
      send(38'(k), 2'd2, 1'b1);
    end
    sr     = 38'd24;
    vs_udr = 1'b1;
    tick(2);
    clr_overflow = 1'b1;
    tick(1);
    clr_overflow = 1'b0;
    check("t5_set_wins", overflow, 1);
    check("t5_level_full", fifo_level, 4);
    tick(3);
    vs_udr = 1'b0;
    tick(4);

    // reset mid-operation with queued entries
    cmd_ready = 1'b1;
    tick(1);
    cmd_ready = 1'b0;
    check("t6_level3", fifo_level, 3);
    sr     = 38'd99;
    vs_udr = 1'b1;
    #2;
    reset_n = 1'b0;
    #1;
    check_reset_outs();
    sb.delete();
    tick(2);
    reset_n = 1'b1;
    tick(10);
    check("t6_no_capture", cmd_valid, 0);
    check("t6_level", fifo_level, 0);
    vs_udr = 1'b0;
    tick(5);
    cmd_ready = 1'b1;
    send(38'h3F_0000_0042, 2'd1, 1'b1);
    check("t6_jdo", jdo, 38'h3F_0000_0042);
    check("t6_drained", sb.size(), 0);
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
